nn_stream_packer: RTL and testbench
===================================

# nn_stream_packer

Packs a stream of 16-bit fixed-point values (inputs, weights, biases) into 64-bit AXI-Stream beats of four lanes each and drives the slave stream port of the neural-network accelerator. Frame boundaries and `tlast` are generated for the accelerator. It sits between the host-side sample source (DMA unpacker or PL test generator) and the `s_axis_*` port of the NN core, producing the 7-beat load frames the core consumes.

## Interface
- `FRAME_BEATS`, default 7: beats per frame expected by the NN core (2..255).
- `aclk`  in  1  system clock; all logic is on the rising edge.
- `areset`  in  1  synchronous, active-high reset.
- `s_tdata`  in  16  input sample, Q-format passed through unchanged.
- `s_tvalid`  in  1  sample valid.
- `s_tlast`  in  1  last sample of the frame.
- `s_tready`  out  1  sample accepted when `s_tvalid && s_tready`.
- `m_axis_tdata`  out  64  packed beat; lane i occupies bits [16i+15:16i].
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tlast`  out  1  last beat of the frame.
- `m_axis_tready`  in  1  downstream ready.
- `frame_err`  out  1  one-cycle pulse on a frame-length mismatch.

## Operation
- Lane fill: the first accepted sample of a beat goes to lane 0, then lanes 1, 2 and 3. The lane counter `lane` runs 0..3 and wraps.
- A beat completes when lane 3 is accepted, or when a sample with `s_tlast=1` is accepted. On a short beat, the unfilled upper lanes are 0x0000.
- The beat counter `beat` runs 0..FRAME_BEATS-1 and counts completed beats in the current frame.
- `m_axis_tlast` for a completed beat is set when either condition holds:
  - the beat contains the `s_tlast` sample, or
  - `beat == FRAME_BEATS-1`.
- After a beat with `m_axis_tlast=1` is completed, `beat` and `lane` both return to 0.
- `frame_err` pulses in the cycle after the completing sample is accepted, in two cases:
  - **Short frame:** `s_tlast` arrives with `beat < FRAME_BEATS-1`.
  - **Long frame:** `beat == FRAME_BEATS-1` completes without `s_tlast`. The forced `tlast` ends the frame, and the following samples start a new frame.
- `s_tlast` on lane 3 of beat FRAME_BEATS-1 is a correct frame: no error.
- Buffering uses two registers:
  - the pack register, which accumulates lanes;
  - the output register, which drives `m_axis_*`.
- A completed beat moves to the output register at the same edge if the output register is empty or is being drained that cycle (`m_axis_tvalid && m_axis_tready`). Otherwise the beat is held in the pack register and `pend` is set.
- `s_tready = !pend`. While `pend=1`, the held beat moves to the output register on the first drain edge and `pend` clears.
- States: FILL (`pend=0`) and HOLD (`pend=1`).
  - FILL→HOLD: beat completes while the output register is full and not draining.
  - HOLD→FILL: output register drains.
- Output stability: once `m_axis_tvalid=1`, `m_axis_tdata` and `m_axis_tlast` stay constant until the handshake completes.

## Timing
- Reset values: `s_tready=1`, `m_axis_tvalid=0`, `m_axis_tdata=0`, `m_axis_tlast=0`, `frame_err=0`, `lane=0`, `beat=0`, `pend=0`.
- Reset mid-frame discards partial lanes, any held beat and the output beat without emitting them. `s_tready` is 1 in the first cycle after reset deasserts.
- Latency: a sample completing a beat at edge k gives `m_axis_tvalid=1` after edge k, assuming no backpressure. `frame_err` is also asserted after edge k, for exactly one cycle.
- Throughput with `m_axis_tready=1`: one sample per cycle and one beat every 4 cycles, with no bubbles.
- Under output stall, at most one completed beat plus one held beat are stored. `s_tready` drops in the cycle after the held beat forms.
- Simultaneous drain and completion in the same cycle: the new beat is loaded at that edge, `pend` stays 0, and `m_axis_tvalid` stays 1.
- `s_tvalid=0` gaps mid-beat preserve `lane` and the partial data indefinitely.

## Test plan
- **Nominal frame:** 28 samples 0x0001..0x001C, `s_tlast` on the 28th, `m_axis_tready=1`.
  - Required: 7 beats; beat 0 = 0x0004_0003_0002_0001; beat 6 = 0x001C_001B_001A_0019 with `tlast=1`; no `frame_err`.
- **Backpressure:** same stimulus with `m_axis_tready` low for 10 cycles starting after beat 0 is valid.
  - Required: `s_tready` falls after the second beat completes, and beat data is stable during the stall.
  - Required: all 7 beats are delivered intact and in order, and `s_tready` returns 1 one cycle after the drain.
- **Short frame:** 6 samples 0x0001..0x0006, `s_tlast` on the 6th.
  - Required: beat 1 = 0x0000_0000_0006_0005 with `tlast=1`; one `frame_err` pulse; the next sample lands in lane 0 of beat 0.
- **Long frame:** 32 samples with no `s_tlast`.
  - Required: beat 6 has `tlast=1` and `frame_err` pulses once; samples 29..32 form beat 0 of the new frame (`tlast=0`).
- **Reset mid-frame:** assert `areset` after 10 samples and 2 beats output with the output stalled; then send the nominal frame.
  - Required: the stalled beat is dropped, all outputs return to reset values, and exactly the 7 nominal beats follow.
- **Gapped input:** `s_tvalid` toggles 1/0 every cycle through the nominal frame.
  - Required: output beats are identical to the nominal case.

Source files
------------

// File: rtl/nn_stream_packer_if.sv
// nn_stream_packer_if
//   AXI-Stream style handshake bundle used on both sides of the packer.
//   W : tdata width (16 on the sample side, 64 on the beat side).
//   Signals: tdata, tvalid, tlast (source -> sink), tready (sink -> source).
//   master modport: the stream source.
//   slave modport: the stream sink.
interface nn_stream_packer_if #(
   parameter int unsigned W = 16
) ();
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tlast;
   logic         tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/nn_stream_packer.sv
// nn_stream_packer
//   Packs 16-bit fixed-point samples four per beat into 64-bit stream beats
//   for the NN core and generates frame boundaries (tlast) of FRAME_BEATS
//   beats. Lane i of a beat occupies bits [16i+15:16i]; short beats are
//   zero-padded in the upper lanes.
// Ports:
//   aclk      : clock, rising edge
//   areset    : synchronous active-high reset
//   s_axis    : 16-bit sample input stream (slave modport)
//   m_axis    : 64-bit beat output stream (master modport)
//   frame_err : one-cycle pulse on a short or long frame
module nn_stream_packer #(
   parameter int unsigned FRAME_BEATS = 7
) (
   input  logic                aclk,
   input  logic                areset,
   nn_stream_packer_if.slave   s_axis,
   nn_stream_packer_if.master  m_axis,
   output logic                frame_err
);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t      state;
   logic [1:0]  lane;
   logic [7:0]  beat;
   logic [63:0] pack_data;
   logic        pack_last;
   logic [63:0] out_data;
   logic        out_valid;
   logic        out_last;

   logic        accept;
   logic        drain;
   logic        last_beat;
   logic        complete;
   logic        beat_tlast;
   logic [63:0] merged;

   assign s_axis.tready = (state == FILL);
   assign m_axis.tdata  = out_data;
   assign m_axis.tvalid = out_valid;
   assign m_axis.tlast  = out_last;

   assign accept    = s_axis.tvalid && (state == FILL);
   assign drain     = out_valid && m_axis.tready;
   assign last_beat = (beat == 8'(FRAME_BEATS - 1));

   always_comb begin
      merged = pack_data;
      merged[lane*16 +: 16] = s_axis.tdata;
      complete   = accept && ((lane == 2'd3) || s_axis.tlast);
      beat_tlast = s_axis.tlast || last_beat;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state     <= FILL;
         lane      <= '0;
         beat      <= '0;
         pack_data <= '0;
         pack_last <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         // Short frame: tlast before the final beat. Long frame: final beat
         // completes without tlast. Both reduce to tlast != last_beat.
         frame_err <= complete && (s_axis.tlast != last_beat);

         if (drain) begin
            out_valid <= 1'b0;
         end

         case (state)
            FILL: begin
               if (accept) begin
                  if (complete) begin
                     lane <= '0;
                     beat <= beat_tlast ? '0 : beat + 8'd1;
                     if (!out_valid || drain) begin
                        out_data  <= merged;
                        out_last  <= beat_tlast;
                        out_valid <= 1'b1;
                        pack_data <= '0;
                     end else begin
                        // Output is stalled: park the finished beat and
                        // stop accepting until the output register drains.
                        pack_data <= merged;
                        pack_last <= beat_tlast;
                        state     <= HOLD;
                     end
                  end else begin
                     pack_data <= merged;
                     lane      <= lane + 2'd1;
                  end
               end
            end
            HOLD: begin
               if (drain) begin
                  out_data  <= pack_data;
                  out_last  <= pack_last;
                  out_valid <= 1'b1;
                  pack_data <= '0;
                  pack_last <= 1'b0;
                  state     <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_nn_stream_packer.sv
// tb_nn_stream_packer
//   Scoreboard bench for nn_stream_packer. A reference model turns accepted
//   samples into expected beats (queue) and expected frame_err pulses; a
//   monitor compares DUT output against the queue head on every negedge.
module tb_nn_stream_packer;
   localparam int unsigned FB = 7;

   logic aclk = 1'b0;
   logic areset = 1'b1;
   logic frame_err;

   always #5 aclk = ~aclk;

   nn_stream_packer_if #(.W(16)) s_if ();
   nn_stream_packer_if #(.W(64)) m_if ();

   nn_stream_packer #(.FRAME_BEATS(FB)) dut (
      .aclk      (aclk),
      .areset    (areset),
      .s_axis    (s_if.slave),
      .m_axis    (m_if.master),
      .frame_err (frame_err)
   );

   typedef struct {
      logic [63:0] data;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   logic [15:0] pend_samp[$];
   int unsigned mbeat;
   int          pushed;
   int          drained;
   logic        exp_err;
   int          n_checks;
   int          n_fail;
   int          rmode;
   int          stall_left;
   bit          stall_req;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Reference model: samples group into beats of four (or fewer on tlast);
   // frame ends on tlast or after FB beats, mismatch between the two is an error.
   function automatic void model_push(input logic [15:0] d, input logic last);
      logic [63:0] word;
      beat_t       b;
      pend_samp.push_back(d);
      if (pend_samp.size() == 4 || last) begin
         word = '0;
         for (int i = 0; i < pend_samp.size(); i++)
            word = word | (64'(pend_samp[i]) << (16 * i));
         b.data = word;
         b.last = last || (mbeat == FB - 1);
         exp_q.push_back(b);
         exp_err = (last && mbeat != FB - 1) || (!last && mbeat == FB - 1);
         mbeat   = b.last ? 0 : mbeat + 1;
         pushed++;
         pend_samp.delete();
      end
   endfunction

   function automatic void model_flush();
      exp_q.delete();
      pend_samp.delete();
      mbeat   = 0;
      pushed  = 0;
      drained = 0;
      exp_err = 1'b0;
   endfunction

   // Downstream ready generator.
   initial begin
      m_if.tready = 1'b1;
      forever begin
         @(posedge aclk);
         #1;
         if (stall_req && m_if.tvalid) begin
            stall_req  = 0;
            stall_left = 10;
         end
         if (stall_left > 0) begin
            m_if.tready = 1'b0;
            stall_left--;
         end else begin
            case (rmode)
               0:       m_if.tready = 1'b1;
               1:       m_if.tready = ($urandom_range(0, 9) < 7);
               default: m_if.tready = 1'b0;
            endcase
         end
      end
   end

   // Monitor: occupancy-derived valid/ready, frame_err, and beat contents.
   initial begin
      int stored;
      forever begin
         @(negedge aclk);
         if (areset === 1'b0) begin
            stored = pushed - drained;
            chk("m_tvalid", 64'(m_if.tvalid), 64'(stored > 0));
            chk("s_tready", 64'(s_if.tready), 64'(stored < 2));
            chk("frame_err", 64'(frame_err), 64'(exp_err));
            exp_err = 1'b0;
            if (m_if.tvalid === 1'b1) begin
               if (exp_q.size() == 0) begin
                  fail_now("beat_unexpected");
               end else begin
                  chk("beat_data", m_if.tdata, exp_q[0].data);
                  chk("beat_last", 64'(m_if.tlast), 64'(exp_q[0].last));
                  if (m_if.tready) begin
                     void'(exp_q.pop_front());
                     drained++;
                  end
               end
            end
         end
      end
   end

   task automatic send(input logic [15:0] d, input logic last, input int idle);
      bit rdy;
      int unsigned n;
      if (idle > 0) begin
         s_if.tvalid = 1'b0;
         repeat (idle) begin
            @(posedge aclk);
            #1;
         end
      end
      s_if.tdata  = d;
      s_if.tlast  = last;
      s_if.tvalid = 1'b1;
      n = 0;
      do begin
         @(negedge aclk);
         rdy = s_if.tready;
         @(posedge aclk);
         #1;
         n++;
      end while (!rdy && n < 100);
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      if (rdy) model_push(d, last);
      else fail_now("s_tready_timeout");
   endtask

   task automatic send_frame(input int n, input int last_at, input int idle);
      for (int i = 1; i <= n; i++)
         send(16'(i), (i == last_at), idle);
   endtask

   task automatic wait_drain();
      int unsigned n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge aclk);
         n++;
      end
      if (exp_q.size() != 0) fail_now("drain_timeout");
      @(posedge aclk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge aclk);
      #1;
      areset      = 1'b1;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      s_if.tdata  = '0;
      repeat (2) @(posedge aclk);
      #1;
      model_flush();
      areset = 1'b0;
      @(negedge aclk);
      chk("rst_tdata", m_if.tdata, 64'h0);
      chk("rst_tlast", 64'(m_if.tlast), 64'h0);
      chk("rst_tvalid", 64'(m_if.tvalid), 64'h0);
      chk("rst_tready", 64'(s_if.tready), 64'h1);
      chk("rst_frame_err", 64'(frame_err), 64'h0);
      @(posedge aclk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rmode       = 0;
      stall_left  = 0;
      stall_req   = 0;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      s_if.tdata  = '0;
      model_flush();
      do_reset();

      // Nominal frame.
      send_frame(28, 28, 0);
      wait_drain();

      // Backpressure: 10-cycle stall once beat 0 is valid.
      stall_req = 1;
      send_frame(28, 28, 0);
      wait_drain();

      // Short frame, then long frame with no tlast.
      send_frame(6, 6, 0);
      wait_drain();
      send_frame(32, 0, 0);
      wait_drain();

      // Reset mid-frame with a stalled output beat and a partial beat.
      send_frame(4, 0, 0);
      wait_drain();
      rmode = 2;
      for (int i = 0; i < 6; i++) send(16'(16'h0100 + i), 1'b0, 0);
      repeat (3) begin
         @(posedge aclk);
         #1;
      end
      do_reset();
      rmode = 0;
      send_frame(28, 28, 0);
      wait_drain();

      // Gapped input.
      send_frame(28, 28, 1);
      wait_drain();

      // Randomized traffic with random backpressure.
      rmode = 1;
      for (int i = 0; i < 300; i++) begin
         int idle;
         idle = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         send(16'($urandom), ($urandom_range(0, 19) == 0), idle);
      end
      rmode = 0;
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
